// File: rtl/ofm_relu_pack.sv
// Output-feature-map post-processing: optional ReLU, arithmetic shift and 8-bit saturation.
// Results are packed four per 32-bit word into a show-ahead FIFO.
module ofm_relu_pack #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TILING_SIZE = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [DATA_WIDTH-1:0]         ofm,
  input  logic                          valid_data,
  input  logic                          relu_en,
  input  logic [3:0]                    shift,
  output logic [31:0]                   pack_data,
  output logic                          pack_valid,
  input  logic                          pack_ready,
  output logic                          tile_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = (TILING_SIZE > 1) ? $clog2(TILING_SIZE) : 1;

  localparam logic signed [DATA_WIDTH-1:0] UMax = DATA_WIDTH'(255);
  localparam logic signed [DATA_WIDTH-1:0] SMax = DATA_WIDTH'(127);
  localparam logic signed [DATA_WIDTH-1:0] SMin = DATA_WIDTH'(-128);

  logic signed [DATA_WIDTH-1:0] s1_data;
  logic                         s1_vld;
  logic signed [DATA_WIDTH-1:0] relu_val;
  logic signed [DATA_WIDTH-1:0] shifted;
  logic [7:0]                   res_byte;

  logic [1:0]    cnt_q;
  logic [23:0]   word_q;
  logic [EW-1:0] elem_q;
  logic          tile_done_q;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic          push, pop, full, wr_en;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_data <= ofm;
      s1_vld  <= valid_data & ~clr;
    end
  end

  always_comb begin
    relu_val = (relu_en && s1_data[DATA_WIDTH-1]) ? '0 : s1_data;
    shifted  = relu_val >>> shift;
    res_byte = shifted[7:0];
    if (relu_en) begin
      if (shifted > UMax) res_byte = 8'hFF;
    end else if (shifted > SMax) begin
      res_byte = 8'h7F;
    end else if (shifted < SMin) begin
      res_byte = 8'h80;
    end
  end

  // Byte lanes 0..2 are staged; lane 3 comes straight from the current result on push.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      word_q      <= '0;
      elem_q      <= '0;
      tile_done_q <= 1'b0;
    end else if (clr) begin
      cnt_q       <= 2'd0;
      elem_q      <= '0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= s1_vld && (elem_q == EW'(TILING_SIZE - 1));
      if (s1_vld) begin
        cnt_q  <= cnt_q + 2'd1;
        elem_q <= (elem_q == EW'(TILING_SIZE - 1)) ? '0 : elem_q + EW'(1);
        case (cnt_q)
          2'd0:    word_q[7:0]   <= res_byte;
          2'd1:    word_q[15:8]  <= res_byte;
          2'd2:    word_q[23:16] <= res_byte;
          default: ;
        endcase
      end
    end
  end

  assign push  = s1_vld && (cnt_q == 2'd3) && !clr;
  assign pop   = pack_valid && pack_ready;
  assign full  = (level_q == LW'(FIFO_DEPTH));
  // When full, a same-edge pop frees the slot the push writes into.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk1) begin
    if (wr_en) mem[wptr_q] <= {res_byte, word_q};
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clr) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      if (wr_en && !pop)      level_q <= level_q + LW'(1);
      else if (!wr_en && pop) level_q <= level_q - LW'(1);
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign pack_valid = (level_q != '0);
  assign pack_data  = pack_valid ? mem[rptr_q] : 32'h0;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign tile_done  = tile_done_q;

endmodule

// File: tb/tb_ofm_relu_pack.sv
// Self-checking bench for ofm_relu_pack: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_ofm_relu_pack;

  localparam int DW = 16;
  localparam int TS = 8;
  localparam int FD = 4;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] ofm = '0;
  logic        valid_data = 1'b0;
  logic        relu_en = 1'b0;
  logic [3:0]  shift = '0;
  logic        pack_ready = 1'b0;
  logic [31:0] pack_data;
  logic        pack_valid;
  logic        tile_done;
  logic [2:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  ofm_relu_pack #(.DATA_WIDTH(DW), .TILING_SIZE(TS), .FIFO_DEPTH(FD)) dut (
    .clk1(clk1), .rst_n(rst_n), .clr(clr), .ofm(ofm), .valid_data(valid_data),
    .relu_en(relu_en), .shift(shift), .pack_data(pack_data), .pack_valid(pack_valid),
    .pack_ready(pack_ready), .tile_done(tile_done), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one element in flight between sampling and packing, then a word queue.
  logic [31:0] mq[$];
  logic [7:0]  part[4];
  int          mcnt = 0;
  int          melem = 0;
  bit          movf = 0;
  bit          mtd = 0;
  bit          pend_vld = 0;
  logic [15:0] pend_data = '0;
  bit          m_pop, m_push;
  logic [31:0] m_word;

  function automatic logic [7:0] ref_byte(input logic [15:0] x, input bit relu, input int sh);
    int v;
    int lo;
    int hi;
    v = int'(signed'(x));
    if (relu && v < 0) v = 0;
    v = v >>> sh;
    lo = relu ? 0 : -128;
    hi = relu ? 255 : 127;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return 8'(v);
  endfunction

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0; melem = 0; movf = 0; mtd = 0; pend_vld = 0;
    end else begin
      m_pop  = (mq.size() != 0) && pack_ready;
      m_push = 0;
      if (clr) begin
        mq.delete();
        mcnt = 0; melem = 0; movf = 0; mtd = 0;
      end else begin
        mtd = 0;
        if (pend_vld) begin
          part[mcnt] = ref_byte(pend_data, relu_en, int'(shift));
          if (mcnt == 3) begin
            m_push = 1;
            m_word = {part[3], part[2], part[1], part[0]};
          end
          mcnt  = (mcnt + 1) % 4;
          mtd   = (melem == TS - 1);
          melem = (melem + 1) % TS;
        end
        if (m_push && mq.size() == FD && !m_pop) begin
          movf = 1;
        end else begin
          if (m_pop) void'(mq.pop_front());
          if (m_push) mq.push_back(m_word);
        end
      end
      pend_vld  = valid_data && !clr;
      pend_data = ofm;
    end
  end

  always @(negedge clk1) begin
    chk("pack_valid", 32'(pack_valid), 32'(mq.size() != 0));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("tile_done", 32'(tile_done), 32'(mtd));
    if (mq.size() != 0) chk("pack_data", pack_data, mq[0]);
    else if (!rst_n) chk("pack_data_rst", pack_data, 32'h0);
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    ofm = v;
    valid_data = 1'b1;
    step();
    valid_data = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_valid", 32'(pack_valid), 32'h0);
    repeat (3) step();
    rst_n = 1'b1;

    // Basic pack with relu and shift, latency of two cycles
    relu_en = 1'b1; shift = 4'd4; pack_ready = 1'b1;
    send(16'h0010); send(16'h0020); send(16'h0030); send(16'h0040);
    chk("lat_early", 32'(pack_valid), 32'h0);
    step();
    chk("lat_valid", 32'(pack_valid), 32'h1);
    chk("basic_word", pack_data, 32'h04030201);
    step();
    chk("lat_one_cycle", 32'(pack_valid), 32'h0);

    // Saturation, signed vs relu
    pack_ready = 1'b0; shift = 4'd0;
    send(16'hFF00); send(16'h7FFF); send(16'h0005); send(16'h0100);
    step();
    chk("sat_relu", pack_data, 32'hFF05FF00);
    pack_ready = 1'b1; step(); pack_ready = 1'b0;
    relu_en = 1'b0;
    send(16'hFF00); send(16'h7FFF); send(16'h0005); send(16'h0100);
    step();
    chk("sat_signed", pack_data, 32'h7F057F80);
    pack_ready = 1'b1; step(); pack_ready = 1'b0;

    // Tile boundary
    do_clr();
    relu_en = 1'b1; shift = 4'd4; pack_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(16 * (i + 1)));
    chk("tile_pre", 32'(tile_done), 32'h0);
    step();
    chk("tile_pulse", 32'(tile_done), 32'h1);
    step();
    chk("tile_post", 32'(tile_done), 32'h0);
    repeat (2) step();

    // Overflow: five words into a four-deep FIFO
    do_clr();
    pack_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(16'(16 * i));
    step();
    chk("ovf_level", 32'(fifo_level), 32'h4);
    chk("ovf_flag", 32'(overflow), 32'h1);
    pack_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain", pack_data, {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)});
      step();
    end
    chk("ovf_empty", 32'(pack_valid), 32'h0);
    pack_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    do_clr();
    for (int i = 0; i < 20; i++) send(16'(16 * i));
    pack_ready = 1'b1; step(); pack_ready = 1'b0;
    chk("full_pp_level", 32'(fifo_level), 32'h4);
    chk("full_pp_ovf", 32'(overflow), 32'h0);
    chk("full_pp_head", pack_data, 32'h07060504);
    pack_ready = 1'b1; repeat (5) step(); pack_ready = 1'b0;

    // Clear mid-word
    do_clr();
    send(16'h0010); send(16'h0020);
    do_clr();
    for (int i = 0; i < 4; i++) send(16'h0010);
    step();
    chk("clr_level", 32'(fifo_level), 32'h1);
    chk("clr_word", pack_data, 32'h01010101);
    chk("clr_ovf", 32'(overflow), 32'h0);
    pack_ready = 1'b1; step(); pack_ready = 1'b0;

    // Reset with words queued
    do_clr();
    for (int i = 0; i < 12; i++) send(16'(16 * i));
    step();
    chk("pre_rst_level", 32'(fifo_level), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(pack_valid), 32'h0);
    chk("rst_mid_level", 32'(fifo_level), 32'h0);
    step();
    rst_n = 1'b1;
    send(16'h00A0); send(16'h00B0); send(16'h00C0); send(16'h00D0);
    step();
    chk("post_rst_word", pack_data, 32'h0D0C0B0A);
    pack_ready = 1'b1; step();

    // Randomized traffic; early phase starves the consumer to exercise overflow
    do_clr();
    for (int n = 0; n < 1500; n++) begin
      valid_data = ($urandom_range(0, 3) != 0);
      ofm        = 16'($urandom);
      relu_en    = 1'($urandom_range(0, 1));
      shift      = 4'($urandom_range(0, 15));
      pack_ready = (n < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      clr        = ($urandom_range(0, 99) == 0);
      step();
    end
    valid_data = 1'b0; clr = 1'b0; pack_ready = 1'b1;
    repeat (8) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ofm_relu_pack.md
OFM_RELU_PACK -- requirements
Module: ofm_relu_pack

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 16, width of incoming partial-sum word.
- TILING_SIZE, 8, outputs per tile; must be a multiple of 4.
- FIFO_DEPTH, 4, output word FIFO entries; power of two, at least 2.

REQ-002 Ports (name, direction, width, meaning):
- clk1, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- clr, in, 1, synchronous clear.
- ofm, in, DATA_WIDTH, signed output-feature-map value.
- valid_data, in, 1, ofm qualifier; there is no backpressure toward this source.
- relu_en, in, 1, enables ReLU and unsigned saturation.
- shift, in, 4, arithmetic right-shift amount.
- pack_data, out, 32, four packed 8-bit results.
- pack_valid, out, 1, pack_data holds a valid word.
- pack_ready, in, 1, consumer accepts the word.
- tile_done, out, 1, one-cycle pulse when the last element of a tile is packed.
- fifo_level, out, clog2(FIFO_DEPTH)+1, number of FIFO entries occupied.
- overflow, out, 1, sticky flag: a word was dropped.

REQ-003 The block shall use one clock, clk1; reset is asynchronous and active-low on rst_n.

Function
REQ-004 Stage 1 shall register ofm into s1_data and valid_data into s1_vld on every clk1 edge.

REQ-005 Stage 2 shall compute the result combinationally from s1_data, treated as signed two's complement:
- if relu_en=1 and the value is negative, the value becomes 0;
- the value is then arithmetically shifted right by shift;
- the shifted value saturates to [0,255] when relu_en=1, else to [-128,127];
- the low 8 bits form the result byte.

REQ-006 relu_en and shift shall be sampled in the cycle s1_vld=1, with no additional registering.

REQ-007 Packer:
- a 2-bit byte counter shall place the byte into lane [8*cnt+7 : 8*cnt] on each edge where s1_vld=1;
- the first element of a word goes to [7:0];
- when cnt=3, the assembled word, including the current byte, is pushed into the FIFO on that same edge and cnt wraps to 0.

REQ-008 Latency: valid_data high in cycle N for the 4th element of a word, with the FIFO empty, shall give pack_valid=1 in cycle N+2.

REQ-009 An element counter (0..TILING_SIZE-1) shall advance on each s1_vld and wrap at TILING_SIZE-1; tile_done shall be high in the cycle after the edge that packs element TILING_SIZE-1.

REQ-010 The FIFO shall be show-ahead:
- pack_valid = (fifo_level != 0);
- pack_data = head entry;
- pop occurs on an edge where pack_valid and pack_ready are both 1.

REQ-011 Simultaneous push and pop shall leave fifo_level unchanged and is legal even when the FIFO is full.

REQ-012 A push when full with no pop shall drop the word, leave the FIFO contents unchanged, and set overflow.

REQ-013 overflow shall stay 1 until clr or reset.

REQ-014 Pop when empty shall have no effect; pack_data is don't-care while pack_valid=0.

REQ-015 Read and write pointers shall wrap modulo FIFO_DEPTH.

REQ-016 clr=1 shall, on the next edge, zero s1_vld, the byte counter, the element counter, the FIFO pointers, fifo_level, overflow and tile_done; valid_data in the clr cycle is discarded.

REQ-017 A clr arriving mid-word shall discard the partial word.

Reset
REQ-018 While rst_n=0 the block shall hold:
- pack_valid=0, pack_data=0, tile_done=0, fifo_level=0, overflow=0;
- s1_vld=0, s1_data=0;
- all counters and pointers at 0.

REQ-019 Reset asserted mid-operation shall discard all buffered data; the first valid_data after reset release starts byte lane 0 and element 0.

Verification
REQ-020 The bench shall cover the following directed scenarios:
- Inputs 0x0010, 0x0020, 0x0030, 0x0040, relu_en=1, shift=4, pack_ready=1 -> pack_data=0x04030201, pack_valid=1 for one cycle, 2 cycles after the 4th input.
- Inputs 0xFF00, 0x7FFF, 0x0005, 0x0100, shift=0: with relu_en=1 -> 0xFF05FF00; with relu_en=0 -> 0x7F057F80.
- 8 consecutive valid inputs -> two words; tile_done pulses exactly once, in the cycle after element 7 is packed.
- pack_ready=0, 20 inputs (5 words), FIFO_DEPTH=4 -> fifo_level=4, overflow=1; the 5th word is dropped; draining yields words 1-4 in order.
- FIFO full, pack_ready=1 in the same cycle the 4th byte of a new word arrives -> no drop, fifo_level stays 4, overflow=0.
- 2 inputs then clr, then 4 inputs 0x0010 (shift=4) -> pack_data=0x01010101; overflow=0; fifo_level=1 before the pop.
- rst_n pulsed low with 3 words queued -> pack_valid=0 and fifo_level=0 immediately; the next 4 inputs produce a correctly lane-aligned word.
